// File: rtl/ram_pkg.sv
// Shared types and helpers for the RAM burst controller.
//   state_e   : controller FSM states
//   next_addr : increment an address with an explicit wrap at depth-1,
//               so non-power-of-two depths wrap correctly
package ram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
    RD_OUT  = 3'd4
  } state_e;

  function automatic int unsigned next_addr(input int unsigned addr,
                                            input int unsigned depth);
    return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Client-side bus of the RAM burst controller.
//   cmd_*  : burst command handshake (valid/ready), wr selects direction,
//            len is a word count 0..DEPTH
//   w*     : write data stream into the controller
//   r*     : read data stream out of the controller
//   done   : one-cycle pulse per completed burst
// master = client datapath, slave = controller.
interface ram_burst_ctrl_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_wr;
  logic [AW-1:0]    cmd_addr;
  logic [AW:0]      cmd_len;
  logic [WIDTH-1:0] wdata;
  logic             wvalid;
  logic             wready;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             rready;
  logic             done;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata, wvalid, rready,
    input  cmd_ready, wready, rdata, rvalid, done
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata, wvalid, rready,
    output cmd_ready, wready, rdata, rvalid, done
  );
endinterface

// File: rtl/sp_ram.sv
// Single-port RAM, DEPTH x WIDTH.
//   clk   : clock
//   w_en  : 1 = write mem[addr] <= wdata; 0 = read, rdata <= mem[addr]
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (one-cycle latency, holds during writes)
module sp_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             w_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) mem[addr] <= wdata;
    else      rdata     <= mem[addr];
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Initiator-side burst controller for one single-port RAM.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : client bus (slave side): command, write stream, read stream, done
//   ram_w_en   : RAM write enable (only high on write-transfer cycles)
//   ram_addr   : RAM address, always the current burst address
//   ram_wdata  : RAM write data, zero unless writing
//   ram_rdata  : RAM registered read data
// Writes stream one word per cycle. Reads take three cycles per word:
// present address, capture RAM output, offer the word until rready.
module ram_burst_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  ram_burst_ctrl_if.slave  bus,
  output logic             ram_w_en,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  state_e           state;
  logic [AW-1:0]    cur_addr;
  logic [AW:0]      remaining;
  logic [WIDTH-1:0] rdata_q;
  logic             done_q;
  logic [AW-1:0]    addr_inc;

  assign addr_inc = AW'(next_addr(32'(cur_addr), DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            cur_addr  <= bus.cmd_addr;
            remaining <= bus.cmd_len;
            // zero-length bursts complete without touching the RAM
            if (bus.cmd_len == '0) done_q <= 1'b1;
            else if (bus.cmd_wr)   state  <= WR;
            else                   state  <= RD_ADDR;
          end
        end
        WR: begin
          if (bus.wvalid) begin
            cur_addr  <= addr_inc;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          // address was presented last cycle, RAM output is valid now
          rdata_q <= ram_rdata;
          state   <= RD_OUT;
        end
        RD_OUT: begin
          if (bus.rready) begin
            cur_addr  <= addr_inc;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              state  <= RD_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.wready    = (state == WR);
  assign bus.rvalid    = (state == RD_OUT);
  assign bus.rdata     = rdata_q;
  assign bus.done      = done_q;

  assign ram_w_en  = (state == WR) && bus.wvalid;
  assign ram_addr  = cur_addr;
  assign ram_wdata = ram_w_en ? bus.wdata : '0;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl driving a real sp_ram.
// A memory model produces expected read words and write beats; they are
// queued when a burst is driven and popped by monitors as the DUT moves data.
module tb_ram_burst_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ram_w_en;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  ram_burst_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus();

  ram_burst_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_w_en(ram_w_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  sp_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
    .clk(clk), .w_en(ram_w_en), .addr(ram_addr),
    .wdata(ram_wdata), .rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk)
    if (!rst && bus.cmd_valid)
      assert (bus.cmd_len <= DEPTH) else $error("illegal cmd_len %0d", bus.cmd_len);

  logic [7:0]  model [DEPTH];
  logic [7:0]  rq[$];   // expected read words
  logic [15:0] wq[$];   // expected write beats {addr, data}

  // read monitor: in-order data and stability under backpressure
  logic       held = 1'b0;
  logic [7:0] held_val;
  always @(negedge clk) begin
    if (bus.rvalid) begin
      if (held) chk("rd_stable", bus.rdata, held_val);
      if (bus.rready) begin
        chk("rd_q_avail", rq.size() > 0, 1);
        if (rq.size() > 0) chk("rd_data", bus.rdata, rq.pop_front());
        held = 1'b0;
      end else begin
        held     = 1'b1;
        held_val = bus.rdata;
      end
    end
  end

  // write monitor: RAM writes only on transfers, to the expected address
  always @(negedge clk) begin
    if (ram_w_en || (bus.wready && bus.wvalid))
      chk("w_en_on_xfer", ram_w_en, bus.wready && bus.wvalid);
    if (!bus.wready) chk("wdata_zero", ram_wdata, 0);
    if (ram_w_en) begin
      chk("wr_q_avail", wq.size() > 0, 1);
      if (wq.size() > 0) chk("wr_beat", {5'd0, ram_addr, ram_wdata}, wq.pop_front());
    end
  end

  typedef struct {
    logic            wr;
    int              addr;
    int              len;
    logic [7:0][7:0] data;      // data[0] is the low byte
    logic [63:0]     stall;     // bit k: wvalid/rready low in cycle T0+k
    int              exp_first; // cycle of first rvalid (0 = not checked)
    int              exp_done;  // cycle of done after the accept edge
  } vec_t;

  vec_t vt[11];

  task automatic run_vec(input vec_t v, input string nm);
    int idx, first_rv, first_wr, done_at, a;
    logic xfer;
    for (int i = 0; i < v.len; i++) begin
      a = (v.addr + i) % DEPTH;
      if (v.wr) begin
        model[a] = v.data[i];
        wq.push_back({a[7:0], v.data[i]});
      end else begin
        rq.push_back(model[a]);
      end
    end
    @(negedge clk);
    chk({nm, "_cmd_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = v.wr;
    bus.cmd_addr  = AW'(v.addr);
    bus.cmd_len   = (AW+1)'(v.len);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    idx = 0; first_rv = 0; first_wr = 0; done_at = 0;
    for (int k = 1; k <= 60 && done_at == 0; k++) begin
      bus.wvalid = v.wr && (idx < v.len) && !v.stall[k];
      bus.wdata  = (v.wr && idx < v.len) ? v.data[idx] : 8'h00;
      bus.rready = !v.wr && !v.stall[k];
      @(negedge clk);
      if (bus.rvalid && first_rv == 0) first_rv = k;
      if (bus.wready && first_wr == 0) first_wr = k;
      if (bus.done) done_at = k;
      xfer = bus.wready && bus.wvalid;
      @(posedge clk); #1;
      if (xfer) idx++;
    end
    bus.wvalid = 1'b0;
    bus.rready = 1'b0;
    chk({nm, "_done_cycle"}, done_at, v.exp_done);
    if (v.exp_first != 0) chk({nm, "_first_rvalid"}, first_rv, v.exp_first);
    if (v.wr && v.len != 0) begin
      chk({nm, "_first_wready"}, first_wr, 1);
      chk({nm, "_words_taken"}, idx, v.len);
    end
    @(negedge clk);
    chk({nm, "_done_pulse"}, bus.done, 0);
    chk({nm, "_idle"}, bus.cmd_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({nm, "_wready"},    bus.wready, 0);
    chk({nm, "_rvalid"},    bus.rvalid, 0);
    chk({nm, "_rdata"},     bus.rdata, 0);
    chk({nm, "_done"},      bus.done, 0);
    chk({nm, "_ram_w_en"},  ram_w_en, 0);
    chk({nm, "_ram_addr"},  ram_addr, 0);
    chk({nm, "_ram_wdata"}, ram_wdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_rv, done_at;
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wdata = '0; bus.wvalid = 1'b0; bus.rready = 1'b0;

    //               wr    addr len data                   stall      first done
    vt[0]  = '{1'b1, 2, 4, 64'h00000000_D4C3B2A1, 64'h0,     0,  5};
    vt[1]  = '{1'b0, 2, 4, 64'h0,                 64'h0,     3, 13};
    vt[2]  = '{1'b1, 6, 4, 64'h00000000_44332211, 64'h0,     0,  5};  // 6,7,0,1
    vt[3]  = '{1'b0, 0, 2, 64'h0,                 64'h0,     3,  7};
    vt[4]  = '{1'b1, 0, 8, 64'h57565554_53525150, 64'h0,     0,  9};  // full depth
    vt[5]  = '{1'b0, 3, 8, 64'h0,                 64'h0,     3, 25};  // full, wraps
    vt[6]  = '{1'b1, 5, 0, 64'h0,                 64'h0,     0,  1};  // zero length
    vt[7]  = '{1'b0, 0, 3, 64'h0,                 64'h7C0,   3, 15};  // word 2 held 5 cycles
    vt[8]  = '{1'b1, 4, 3, 64'h00000000_00C9B8A7, 64'h14,    0,  6};  // wvalid gaps
    vt[9]  = '{1'b0, 4, 3, 64'h0,                 64'h0,     3, 10};
    vt[10] = '{1'b0, 0, 5, 64'h0,                 64'h0,     3, 16};  // after abort

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);

    for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // zero-length burst, then a read accepted in its done cycle
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 3'd3; bus.cmd_len = '0;
    @(posedge clk); #1;
    rq.push_back(model[1]);
    bus.cmd_wr = 1'b0; bus.cmd_addr = 3'd1; bus.cmd_len = 4'd1;
    @(negedge clk);
    chk("b2b_done", bus.done, 1);
    chk("b2b_ready_in_done", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.rready = 1'b1;
    first_rv = 0; done_at = 0;
    for (int k = 1; k <= 20 && done_at == 0; k++) begin
      @(negedge clk);
      if (bus.rvalid && first_rv == 0) first_rv = k;
      if (bus.done) done_at = k;
    end
    bus.rready = 1'b0;
    chk("b2b_first_rvalid", first_rv, 3);
    chk("b2b_done_cycle", done_at, 4);

    // reset after 2 of 5 writes: only those 2 reach the RAM
    model[0] = 8'hE0; model[1] = 8'hE1;
    wq.push_back({8'd0, 8'hE0});
    wq.push_back({8'd1, 8'hE1});
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = '0; bus.cmd_len = 4'd5;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.wvalid = 1'b1; bus.wdata = 8'hE0;
    @(posedge clk); #1;
    bus.wdata = 8'hE1;
    @(posedge clk); #1;
    bus.wdata = 8'hE2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0; bus.wvalid = 1'b0;
    run_vec(vt[10], "abort_rd");

    repeat (2) @(posedge clk);
    chk("wr_q_drained", wq.size(), 0);
    chk("rd_q_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
